// File: rtl/fft_result_reader_if.sv
// Port bundle of fft_result_reader: bank read side toward fft_top plus the
// serial sample stream toward the consumer.
interface fft_result_reader_if #(
  parameter int ADDR_W = 9,
  parameter int DW     = 17
);
  logic              iFFT_RDY;
  logic [ADDR_W-1:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
  logic [DW-1:0]     iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3;
  logic [DW-1:0]     oDATA;
  logic              oVALID, iREADY, oSOP, oEOP, oBUSY, oOVR;

  modport master (
    input  iFFT_RDY, iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3, iREADY,
    output oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
           oDATA, oVALID, oSOP, oEOP, oBUSY, oOVR
  );

  modport slave (
    output iFFT_RDY, iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3, iREADY,
    input  oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
           oDATA, oVALID, oSOP, oEOP, oBUSY, oOVR
  );
endinterface

// File: rtl/fft_result_reader.sv
// Streams a finished transform out of the four fft_top result banks in natural
// order, with a credit-limited skid FIFO hiding the bank read latency.
module fft_result_reader #(
  parameter int N      = 2048,
  parameter int ADDR_W = 9,
  parameter int DW     = 17,
  parameter int RD_LAT = 1
) (
  input  logic                iCLK,
  input  logic                iRESET,
  fft_result_reader_if.master bus
);
  localparam int D  = RD_LAT + 1;
  localparam int NW = ADDR_W + 2;
  localparam int CW = $clog2(D + 1);
  localparam int IW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  typedef struct packed { logic [1:0] bank; logic sop; logic eop; } tag_t;
  typedef struct packed { logic [DW-1:0] data; logic sop; logic eop; } ent_t;

  state_t            state_q, state_d;
  logic [NW-1:0]     n_q, n_d;
  logic              rdy_hist, ovr_q;
  logic              start_edge, start_ok, issue, credit, xfer, eop_xfer, push;
  logic [RD_LAT:1]   vld_pipe;
  tag_t [RD_LAT:1]   tag_pipe;
  tag_t              tag_now;
  ent_t              fifo [D];
  logic [CW-1:0]     fifo_cnt, inflight;
  logic [CW:0]       occ;
  logic [IW-1:0]     wr_idx;
  logic [3:0][DW-1:0] bank_data;
  logic [DW-1:0]     din;

  // History resets high so a level-high ready at reset release is not a start.
  assign start_edge = bus.iFFT_RDY & ~rdy_hist;
  assign xfer       = bus.oVALID & bus.iREADY;
  assign eop_xfer   = xfer & fifo[0].eop;

  always_comb begin
    inflight = '0;
    for (int k = 1; k <= RD_LAT; k++) inflight = inflight + CW'(vld_pipe[k]);
  end

  // A transfer this cycle frees its entry, so it counts toward the credit.
  assign occ    = {1'b0, fifo_cnt} + {1'b0, inflight};
  assign credit = occ < ((CW+1)'(D) + {{CW{1'b0}}, xfer});

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q  <= IDLE;
      n_q      <= '0;
      rdy_hist <= 1'b1;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      rdy_hist <= bus.iFFT_RDY;
      ovr_q    <= start_edge & ~start_ok;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    issue    = 1'b0;
    start_ok = 1'b0;
    unique case (state_q)
      IDLE:  start_ok = start_edge;
      READ:  issue = credit;
      DRAIN: begin
        if (eop_xfer) state_d = IDLE;
        start_ok = start_edge & eop_xfer;
      end
      default: state_d = IDLE;
    endcase
    if (start_ok) issue = 1'b1;
    if (issue) begin
      state_d = READ;
      n_d     = n_q + NW'(1);
      if (n_q == NW'(N - 1)) begin
        state_d = DRAIN;
        n_d     = '0;
      end
    end
  end

  assign tag_now = '{bank: n_q[1:0], sop: (n_q == '0), eop: (n_q == NW'(N - 1))};

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      tag_pipe[1] <= tag_now;
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  assign bank_data = {bus.iDATA_RE_3, bus.iDATA_RE_2, bus.iDATA_RE_1, bus.iDATA_RE_0};
  assign din       = bank_data[tag_pipe[RD_LAT].bank];
  assign push      = vld_pipe[RD_LAT];
  assign wr_idx    = IW'(fifo_cnt - CW'(xfer));

  // Shift FIFO: entry 0 is the output register, so a stall never disturbs it.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      fifo_cnt <= '0;
      for (int i = 0; i < D; i++) fifo[i] <= '0;
    end else begin
      if (xfer) for (int i = 0; i < D - 1; i++) fifo[i] <= fifo[i+1];
      if (push) fifo[wr_idx] <= '{data: din, sop: tag_pipe[RD_LAT].sop, eop: tag_pipe[RD_LAT].eop};
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(xfer);
    end
  end

  assign bus.oVALID     = (fifo_cnt != '0);
  assign bus.oDATA      = fifo[0].data;
  assign bus.oSOP       = bus.oVALID & fifo[0].sop;
  assign bus.oEOP       = bus.oVALID & fifo[0].eop;
  assign bus.oBUSY      = (state_q != IDLE);
  assign bus.oOVR       = ovr_q;
  assign bus.oADDR_RD_0 = n_q[NW-1:2];
  assign bus.oADDR_RD_1 = n_q[NW-1:2];
  assign bus.oADDR_RD_2 = n_q[NW-1:2];
  assign bus.oADDR_RD_3 = n_q[NW-1:2];
endmodule
